decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  RV32I instruction decode stage; producer side of the ALU control interface.
//  Accepts fetched {pc, instr} over valid/ready and decodes it into alu_op, operand
//  selects, register indices, immediate and control flags.
//  Holds the decoded result in one registered output slot (latency 1) feeding execute.
// PARAMETERS
//  PC_W   32  PC width; passed through unchanged.
// PORTS
//  clk          in   1     single clock; all state updates on rising edge
//  rst_n        in   1     synchronous, active-low reset
//  in_valid     in   1     fetch offers pc/instr
//  in_ready     out  1     decode can accept this cycle
//  in_pc        in   PC_W  PC of offered instruction
//  in_instr     in   32    raw instruction word
//  flush        in   1     discard held and offered instruction (branch redirect)
//  out_valid    out  1     decoded bundle valid
//  out_ready    in   1     execute accepts bundle
//  out_pc       out  PC_W  registered PC
//  out_alu_op   out  4     ALU op code, shared package encoding
//  out_src_a    out  2     0=rs1, 1=pc, 2=zero
//  out_src_b    out  1     0=rs2, 1=imm
//  out_rs1      out  5     source register 1 index
//  out_rs2      out  5     source register 2 index
//  out_rd       out  5     destination index
//  out_imm      out  32    sign-extended immediate
//  out_reg_we   out  1     writes rd (forced 0 when rd==0 or illegal)
//  out_mem_rd   out  1     load
//  out_mem_wr   out  1     store
//  out_branch   out  1     conditional branch; out_jump 1 for JAL/JALR (same encoding width)
//  out_illegal  out  1     unsupported encoding
// BEHAVIOUR
//  Reset (rst_n=0 at edge): out_valid=0; all out_* bundle fields = 0.
//  in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
//  On accept: bundle register loads decode(in_instr), out_pc<=in_pc, out_valid<=1.
//  out_valid && !out_ready && !flush: all out_* held bit-stable.
//  out_valid && out_ready && !in_valid: out_valid<=0; fields may hold stale.
//  flush=1: out_valid<=0 next edge; offered input not captured that cycle (flush wins).
//  Decode (ALU enc: ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9):
//   OP 0110011: funct3/funct7 -> op; f7=0100000 legal only for f3 000(SUB)/101(SRA).
//   OP-IMM 0010011: src_b=imm I-type; f3 001 needs f7=0; f3 101 f7 0 SRL, 0100000 SRA.
//   LOAD 0000011 / STORE 0100011: ADD, src_b=imm (I / S), mem_rd / mem_wr.
//   BRANCH 1100011: imm B; op SUB for BEQ/BNE, SLT for BLT/BGE, SLTU BLTU/BGEU; f3 010/011 illegal.
//   LUI 0110111: src_a=zero, imm U; AUIPC 0010111: src_a=pc, imm U; both ADD.
//   JAL 1101111: src_a=pc, imm J; JALR 1100111 (f3=000): src_a=rs1, imm I; ADD, jump=1.
//   Any other opcode/funct: illegal=1, alu_op=ADD, reg_we/mem_*/branch/jump=0.
//  Stores/branches: reg_we=0. Immediates sign-extended from instr[31].
// STRUCTURE
//  Package rv32i_pkg: alu_op_e enum (values above), opcode_e localparams, src_a_e.
//  Sub-module imm_gen (instr -> I/S/B/U/J immediate, combinational); rest inline.
// TESTING
//  add x3,x1,x2 0x002081B3 -> op=0, rs1=1 rs2=2 rd=3, src_b=0, reg_we=1, out_valid next cycle.
//  sub x5,x6,x7 0x407302B3 -> op=1; srai x2,x1,3 0x4030D113 -> op=9, imm=3, src_b=1.
//  addi x1,x0,-1 0xFFF00093 -> imm=0xFFFFFFFF; lui x4,0x12345 0x12345237 -> imm=0x12345000, src_a=2.
//  0xFFFFFFFF -> illegal=1, reg_we=0; addi x0,x0,1 -> reg_we=0, illegal=0.
//  out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle stable, second instr taken after.
//  flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, offered instr dropped; rst_n=0 mid-stream -> all outs 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: ALU op encoding, operand selects, opcodes and the
// decoded bundle carried from decode to execute.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     alu_op;
    src_a_e      src_a;
    logic        src_b;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: all five RV32I immediate formats, sign-extended from
// instr[31]; the decoder picks one by opcode.
module imm_gen (
  input  logic [31:7] i_instr,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_b,
  output logic [31:0] o_imm_u,
  output logic [31:0] o_imm_j
);

  always_comb begin
    o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    o_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
               i_instr[11:8], 1'b0};
    o_imm_u = {i_instr[31:12], 12'b0};
    o_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
               i_instr[30:21], 1'b0};
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: accepts {pc, instr} over valid/ready and presents the
// decoded bundle from a single registered output slot (latency 1).
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      out_alu_op,
  output logic [1:0]      out_src_a,
  output logic            out_src_b,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic            out_reg_we,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0]     w_imm_sh;
  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic            w_bad;
  logic            w_accept;
  dec_t            w_dec;
  dec_t            r_dec;
  logic            r_valid;
  logic [PC_W-1:0] r_pc;

  imm_gen u_imm_gen (
    .i_instr (in_instr[31:7]),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_b (w_imm_b),
    .o_imm_u (w_imm_u),
    .o_imm_j (w_imm_j)
  );

  always_comb begin
    w_opc    = in_instr[6:0];
    w_f3     = in_instr[14:12];
    w_f7     = in_instr[31:25];
    w_imm_sh = {27'b0, in_instr[24:20]};
  end

  always_comb begin
    w_bad          = 1'b0;
    w_dec          = '0;
    w_dec.alu_op   = ALU_ADD;
    w_dec.src_a    = SRC_A_RS1;
    w_dec.rs1      = in_instr[19:15];
    w_dec.rs2      = in_instr[24:20];
    w_dec.rd       = in_instr[11:7];
    case (w_opc)
      OPC_OP: begin
        w_dec.reg_we = 1'b1;
        if (w_f7 == F7_ZERO) begin
          case (w_f3)
            3'b000:  w_dec.alu_op = ALU_ADD;
            3'b001:  w_dec.alu_op = ALU_SLL;
            3'b010:  w_dec.alu_op = ALU_SLT;
            3'b011:  w_dec.alu_op = ALU_SLTU;
            3'b100:  w_dec.alu_op = ALU_XOR;
            3'b101:  w_dec.alu_op = ALU_SRL;
            3'b110:  w_dec.alu_op = ALU_OR;
            default: w_dec.alu_op = ALU_AND;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
          w_dec.alu_op = ALU_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
          w_dec.alu_op = ALU_SRA;
        end else begin
          w_bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_dec.reg_we = 1'b1;
        w_dec.src_b  = 1'b1;
        w_dec.imm    = w_imm_i;
        case (w_f3)
          3'b000: w_dec.alu_op = ALU_ADD;
          3'b010: w_dec.alu_op = ALU_SLT;
          3'b011: w_dec.alu_op = ALU_SLTU;
          3'b100: w_dec.alu_op = ALU_XOR;
          3'b110: w_dec.alu_op = ALU_OR;
          3'b111: w_dec.alu_op = ALU_AND;
          // shifts carry only the 5-bit shamt; the upper field is funct7
          3'b001: begin
            w_dec.alu_op = ALU_SLL;
            w_dec.imm    = w_imm_sh;
            w_bad        = (w_f7 != F7_ZERO);
          end
          default: begin
            w_dec.imm = w_imm_sh;
            if (w_f7 == F7_ZERO)     w_dec.alu_op = ALU_SRL;
            else if (w_f7 == F7_ALT) w_dec.alu_op = ALU_SRA;
            else                     w_bad = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        w_dec.reg_we = 1'b1;
        w_dec.mem_rd = 1'b1;
        w_dec.src_b  = 1'b1;
        w_dec.imm    = w_imm_i;
        w_bad        = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        w_dec.mem_wr = 1'b1;
        w_dec.src_b  = 1'b1;
        w_dec.imm    = w_imm_s;
        w_bad        = w_f3[2] || (w_f3 == 3'b011);
      end
      OPC_BRANCH: begin
        w_dec.branch = 1'b1;
        w_dec.imm    = w_imm_b;
        case (w_f3)
          3'b000, 3'b001: w_dec.alu_op = ALU_SUB;
          3'b100, 3'b101: w_dec.alu_op = ALU_SLT;
          3'b110, 3'b111: w_dec.alu_op = ALU_SLTU;
          default:        w_bad = 1'b1;
        endcase
      end
      OPC_LUI: begin
        w_dec.reg_we = 1'b1;
        w_dec.src_a  = SRC_A_ZERO;
        w_dec.src_b  = 1'b1;
        w_dec.imm    = w_imm_u;
      end
      OPC_AUIPC: begin
        w_dec.reg_we = 1'b1;
        w_dec.src_a  = SRC_A_PC;
        w_dec.src_b  = 1'b1;
        w_dec.imm    = w_imm_u;
      end
      OPC_JAL: begin
        w_dec.reg_we = 1'b1;
        w_dec.jump   = 1'b1;
        w_dec.src_a  = SRC_A_PC;
        w_dec.src_b  = 1'b1;
        w_dec.imm    = w_imm_j;
      end
      OPC_JALR: begin
        w_dec.reg_we = 1'b1;
        w_dec.jump   = 1'b1;
        w_dec.src_b  = 1'b1;
        w_dec.imm    = w_imm_i;
        w_bad        = (w_f3 != 3'b000);
      end
      default: w_bad = 1'b1;
    endcase
    // illegal encodings keep register indices but carry no side effects
    if (w_bad) begin
      w_dec.alu_op  = ALU_ADD;
      w_dec.src_a   = SRC_A_RS1;
      w_dec.src_b   = 1'b0;
      w_dec.imm     = '0;
      w_dec.reg_we  = 1'b0;
      w_dec.mem_rd  = 1'b0;
      w_dec.mem_wr  = 1'b0;
      w_dec.branch  = 1'b0;
      w_dec.jump    = 1'b0;
      w_dec.illegal = 1'b1;
    end
    if (w_dec.rd == 5'd0) w_dec.reg_we = 1'b0;
  end

  always_comb begin
    in_ready = !r_valid || out_ready;
    w_accept = in_valid && in_ready;
  end

  // flush has priority over an accept offered in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_dec   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pc    <= in_pc;
      r_dec   <= w_dec;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    out_valid   = r_valid;
    out_pc      = r_pc;
    out_alu_op  = r_dec.alu_op;
    out_src_a   = r_dec.src_a;
    out_src_b   = r_dec.src_b;
    out_rs1     = r_dec.rs1;
    out_rs2     = r_dec.rs2;
    out_rd      = r_dec.rd;
    out_imm     = r_dec.imm;
    out_reg_we  = r_dec.reg_we;
    out_mem_rd  = r_dec.mem_rd;
    out_mem_wr  = r_dec.mem_wr;
    out_branch  = r_dec.branch;
    out_jump    = r_dec.jump;
    out_illegal = r_dec.illegal;
  end

endmodule
